// File: rtl/regfile_scoreboard_if.sv
// Decode <-> register file bundle: read ports, issue, write-back,
// flush and debug read. master = decode side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     issue_valid;
  logic                     issue_wr;
  logic [ADDR_W-1:0]        issue_dst;
  logic                     issue_stall;
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
    output wb_valid, wb_addr, wb_data, flush, dbg_addr,
    input  rd_data, rd_ready, issue_stall, dbg_data
  );

  modport slave (
    input  rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
    input  wb_valid, wb_addr, wb_data, flush, dbg_addr,
    output rd_data, rd_ready, issue_stall, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with pending-write scoreboard, write-back
// bypass and issue stall. Ports: clk, rst (async active-low), bus (slave).
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 15,
  parameter int CNT_W    = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [DATA_W-1:0] reg_q [NREG];
  logic [DATA_W-1:0] reg_d [NREG];
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [DATA_W-1:0] dbg_q;
  logic [DATA_W-1:0] dbg_d;

  logic [ADDR_W-1:0]        ra [NUM_RD];
  logic [NUM_RD-1:0]        byp;
  logic [NUM_RD-1:0]        rdy;
  logic [NUM_RD*DATA_W-1:0] rdat;
  logic [NREG-1:0]          inc;
  logic [NREG-1:0]          dec;
  logic                     stall;
  logic                     accept;

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i]  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      byp[i] = bus.wb_valid && (bus.wb_addr == ra[i]);
    end
  end

  // Outputs are forced to their reset values while rst is low so a
  // write-back presented during reset cannot leak through the bypass.
  always_comb begin
    rdat = '0;
    rdy  = '1;
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (ra[i] != ZR) begin
          rdat[i*DATA_W +: DATA_W] =
            byp[i] ? bus.wb_data : reg_q[ra[i]];
          rdy[i] = (cnt_q[ra[i]] == '0) ||
                   ((cnt_q[ra[i]] == ONE) && byp[i]);
        end
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    if (rst && bus.issue_valid) begin
      stall = |(bus.rd_en & ~rdy);
      if (bus.issue_wr && (bus.issue_dst != ZR) &&
          (cnt_q[bus.issue_dst] == CMAX))
        stall = 1'b1;
    end
  end

  assign accept = bus.issue_valid && !stall && !bus.flush;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      reg_d[r] = reg_q[r];
      cnt_d[r] = cnt_q[r];
      inc[r] = accept && bus.issue_wr &&
               (bus.issue_dst == ADDR_W'(r));
      dec[r] = bus.wb_valid && (bus.wb_addr == ADDR_W'(r)) &&
               (cnt_q[r] != '0);
      if (bus.wb_valid && (bus.wb_addr == ADDR_W'(r)) &&
          (ADDR_W'(r) != ZR))
        reg_d[r] = bus.wb_data;
      if (bus.flush || (ADDR_W'(r) == ZR))
        cnt_d[r] = '0;
      else if (inc[r] && !dec[r])
        cnt_d[r] = cnt_q[r] + ONE;
      else if (dec[r] && !inc[r])
        cnt_d[r] = cnt_q[r] - ONE;
    end
  end

  always_comb begin
    dbg_d = '0;
    if (bus.dbg_addr != ZR)
      dbg_d = reg_q[bus.dbg_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      dbg_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= reg_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      dbg_q <= dbg_d;
    end
  end

  assign bus.rd_data     = rdat;
  assign bus.rd_ready    = rdy;
  assign bus.issue_stall = stall;
  assign bus.dbg_data    = dbg_q;
endmodule
